// File: rtl/conv_window_ctrl.sv
`default_nettype none
//----------------------------------------------------------------------------
// conv_window_ctrl - raster-scan KSIZE x KSIZE window sequencer; CONV_WIN_STRIDE2_EN selects stride 2. Rev 1.0
//----------------------------------------------------------------------------
module conv_window_ctrl #(
  parameter int COLS  = 28,
  parameter int ROWS  = 28,
  parameter int KSIZE = 5,
  parameter int CW    = $clog2(COLS),
  parameter int RW    = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          buf_en,
  input  logic          out_ready,
  output logic          win_valid,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          busy,
  output logic          frame_done
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FILL  = 2'd1;
  localparam logic [1:0] c_RUN   = 2'd2;
  localparam logic [1:0] c_DRAIN = 2'd3;

  localparam logic [CW-1:0] c_COL_LAST      = CW'(COLS - 1);
  localparam logic [RW-1:0] c_ROW_LAST      = RW'(ROWS - 1);
  localparam logic [CW-1:0] c_COL_Q         = CW'(KSIZE - 1);
  localparam logic [RW-1:0] c_ROW_Q         = RW'(KSIZE - 1);
  localparam logic [RW-1:0] c_ROW_FILL_LAST = RW'(KSIZE - 2);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_win_valid;
  logic [RW-1:0] r_win_row;
  logic [CW-1:0] r_win_col;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_drain_exit;
  logic          w_stride_ok;
  logic          w_qual;
  logic          w_col_last;
  logic [RW-1:0] w_wrow;
  logic [CW-1:0] w_wcol;

  assign w_wrow     = r_row - c_ROW_Q;
  assign w_wcol     = r_col - c_COL_Q;
  assign w_col_last = (r_col == c_COL_LAST);

`ifdef CONV_WIN_STRIDE2_EN
  // Odd-position windows still shift the line buffer, they are just never presented.
  assign w_stride_ok = ~w_wrow[0] & ~w_wcol[0];
`else
  assign w_stride_ok = 1'b1;
`endif

  assign w_qual = w_accept && (r_row >= c_ROW_Q) && (r_col >= c_COL_Q) && w_stride_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_state_nxt = c_FILL;
      c_FILL:  if (w_accept && r_row == c_ROW_FILL_LAST && w_col_last) w_state_nxt = c_RUN;
      c_RUN:   if (w_accept && r_row == c_ROW_LAST && w_col_last) w_state_nxt = c_DRAIN;
      c_DRAIN: if (w_drain_exit) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    // A held, unconsumed window blocks the source so the line-buffer taps stay put.
    w_in_ready   = !rst && (r_state != c_DRAIN) && !(r_win_valid && !out_ready);
    w_accept     = in_valid && w_in_ready;
    w_drain_exit = !rst && (r_state == c_DRAIN) && (!r_win_valid || out_ready);
    in_ready     = w_in_ready;
    buf_en       = w_accept;
    busy         = (r_state != c_IDLE);
    frame_done   = w_drain_exit;
    win_valid    = r_win_valid;
    win_row      = r_win_row;
    win_col      = r_win_col;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_win_valid <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
    end else begin
      if (w_drain_exit) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_accept) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      if (w_qual) begin
        r_win_valid <= 1'b1;
        r_win_row   <= w_wrow;
        r_win_col   <= w_wcol;
      end else if (out_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_ctrl.sv
`default_nettype none
//----------------------------------------------------------------------------
// tb_conv_window_ctrl - vector table plus scoreboarded frame runs. Rev 1.0
//----------------------------------------------------------------------------
module tb_conv_window_ctrl;

  localparam int COLS  = 28;
  localparam int ROWS  = 28;
  localparam int KSIZE = 5;
  localparam int NPIX  = COLS * ROWS;
`ifdef CONV_WIN_STRIDE2_EN
  localparam int EXP_WIN = 144;
`else
  localparam int EXP_WIN = 576;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, buf_en, win_valid, busy, frame_done;
  logic [4:0] win_row;
  logic [4:0] win_col;

  always #5 clk = ~clk;

  conv_window_ctrl #(.COLS(COLS), .ROWS(ROWS), .KSIZE(KSIZE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .buf_en(buf_en), .out_ready(out_ready), .win_valid(win_valid),
    .win_row(win_row), .win_col(win_col), .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    logic rst; logic iv; logic ordy;
    logic e_rdy; logic e_ben; logic e_busy; logic e_wv;
  } vec_t;

  typedef struct { int r; int c; } win_t;

  win_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   px_row, px_col;
  bit   m_wv, m_drain, m_fd;
  int   dut_win, ben_cnt, fd_cnt, stall_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    px_row = 0; px_col = 0;
    m_wv = 0; m_drain = 0; m_fd = 0;
  endtask

  task automatic do_cycle(input logic iv, input logic ordy);
    bit acc, qual, exp_rdy;
    in_valid  = iv;
    out_ready = ordy;
    @(negedge clk);
    exp_rdy = !m_drain && !(m_wv && !ordy);
    acc     = iv && exp_rdy;
    m_fd    = m_drain && (!m_wv || ordy);
    chk("in_ready", in_ready, exp_rdy);
    chk("buf_en", buf_en, acc);
    chk("win_valid", win_valid, m_wv);
    chk("busy", busy, (m_drain || px_row != 0 || px_col != 0));
    chk("frame_done", frame_done, m_fd);
    if (buf_en) ben_cnt++;
    if (frame_done) fd_cnt++;
    if (win_valid && ordy) dut_win++;
    if (m_wv && q.size() > 0) begin
      chk("win_row", win_row, q[0].r);
      chk("win_col", win_col, q[0].c);
      if (ordy) void'(q.pop_front());
    end
    qual = acc && px_row >= KSIZE-1 && px_col >= KSIZE-1;
`ifdef CONV_WIN_STRIDE2_EN
    qual = qual && ((px_row - (KSIZE-1)) % 2 == 0) && ((px_col - (KSIZE-1)) % 2 == 0);
`endif
    if (qual) q.push_back('{px_row - (KSIZE-1), px_col - (KSIZE-1)});
    m_wv = qual ? 1'b1 : (ordy ? 1'b0 : m_wv);
    if (m_fd) m_drain = 0;
    if (acc) begin
      if (px_col == COLS-1) begin
        px_col = 0;
        if (px_row == ROWS-1) begin px_row = 0; m_drain = 1; end
        else px_row++;
      end else begin
        px_col++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_frame();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_buf_en", buf_en, 0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_win_valid", win_valid, 0);
    chk("post_rst_win_row", win_row, 0);
    chk("post_rst_win_col", win_col, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_frame_done", frame_done, 0);
    chk("post_rst_in_ready", in_ready, 1);
    model_reset();
    @(posedge clk); #1;
  endtask

  // mode 0: streaming, 1: stall at window (0,3), 2: random handshakes, 3: reset at pixel (10,7)
  task automatic run_frame(input int mode);
    int   cyc;
    logic iv, ordy;
    dut_win = 0; ben_cnt = 0; fd_cnt = 0; stall_n = 0; cyc = 0; m_fd = 0;
    while (!m_fd && cyc < 8000) begin
      if (mode == 3 && px_row == 10 && px_col == 7) begin
        reset_mid_frame();
        return;
      end
      iv = 1'b1; ordy = 1'b1;
      if (mode == 2) begin
        iv   = ($urandom_range(1, 0) == 1);
        ordy = ($urandom_range(3, 0) != 0);
      end
      if (mode == 1 && m_wv && q.size() > 0 && q[0].r == 0 && q[0].c == 3 && stall_n < 10) begin
        ordy = 1'b0;
        stall_n++;
      end
      do_cycle(iv, ordy);
      cyc++;
    end
    chk("frame_finished", m_fd, 1);
    chk("windows_consumed", dut_win, EXP_WIN);
    chk("buf_en_cycles", ben_cnt, NPIX);
    chk("frame_done_pulses", fd_cnt, 1);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      rst = vecs[i].rst; in_valid = vecs[i].iv; out_ready = vecs[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_rdy);
      chk($sformatf("vec%0d_buf_en", i), buf_en, vecs[i].e_ben);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d_win_valid", i), win_valid, vecs[i].e_wv);
      if (i == 0) begin
        chk("reset_win_row", win_row, 0);
        chk("reset_win_col", win_col, 0);
        chk("reset_frame_done", frame_done, 0);
      end
      @(posedge clk); #1;
    end

    model_reset();
    run_frame(0);
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
